// File: rtl/gray_codec.sv
// Gray code converter / stepper with a single valid/ready output register.
// Optional macro GRAY_CODEC_STEP_EN enables modes 10 (gray +1) and 11 (gray -1).
module gray_codec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    typedef struct packed {
        logic [1:0]       mode;
        logic             err;
        logic [WIDTH-1:0] data;
    } rsp_t;

    rsp_t rsp_q, rsp_d;
    logic vld_q;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray decode: each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    always_comb begin
        rsp_d      = '0;
        rsp_d.mode = in_mode;
        case (in_mode)
            2'b00: rsp_d.data = bin2gray(in_data);
            2'b01: rsp_d.data = gray2bin(in_data);
`ifdef GRAY_CODEC_STEP_EN
            2'b10: rsp_d.data = bin2gray(gray2bin(in_data) + WIDTH'(1));
            2'b11: rsp_d.data = bin2gray(gray2bin(in_data) - WIDTH'(1));
`else
            default: rsp_d.err = 1'b1;
`endif
        endcase
    end

    assign in_ready = !vld_q || out_ready;

    // Loading on accept also covers the zero-bubble case where the old word drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            rsp_q <= '0;
        end else if (in_valid && in_ready) begin
            vld_q <= 1'b1;
            rsp_q <= rsp_d;
        end else if (out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign out_valid = vld_q;
    assign out_mode  = rsp_q.mode;
    assign out_data  = rsp_q.data;
    assign out_err   = rsp_q.err;

endmodule

// File: tb/tb_gray_codec.sv
// Randomized + directed bench for gray_codec (WIDTH=4) with a queue scoreboard.
// Expected results follow GRAY_CODEC_STEP_EN the same way the design build does.
module tb_gray_codec;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_mode = 2'b00;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_mode;
    logic [W-1:0] out_data;
    logic         out_err;

    gray_codec #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   n_out = 0;
    int   cyc = 0;
    int   out_cycles[$];

    always @(posedge clk) cyc++;

    // Reference: gray sequence as a table of position -> code word.
    function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] d);
        exp_t e;
        int   tbl[16];
        int   pos;
        pos = 0;
        for (int n = 0; n < 16; n++) begin
            tbl[n] = n ^ (n / 2);
            if (tbl[n] == int'(d)) pos = n;
        end
        e.mode = m;
        e.err  = 1'b0;
        e.data = '0;
        case (m)
            2'b00: e.data = W'(tbl[int'(d)]);
            2'b01: e.data = W'(pos);
`ifdef GRAY_CODEC_STEP_EN
            2'b10: e.data = W'(tbl[(pos + 1) % 16]);
            default: e.data = W'(tbl[(pos + 15) % 16]);
`else
            default: e.err = 1'b1;
`endif
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: an output transfer happens at the next posedge when both are high here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            total++;
            n_out++;
            out_cycles.push_back(cyc);
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got data=%b mode=%b err=%b, none expected",
                         out_data, out_mode, out_err);
            end else begin
                e = q.pop_front();
                if (out_data !== e.data || out_mode !== e.mode || out_err !== e.err) begin
                    bad++;
                    $display("FAIL scoreboard: got data=%b mode=%b err=%b want data=%b mode=%b err=%b",
                             out_data, out_mode, out_err, e.data, e.mode, e.err);
                end
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [W-1:0] d, input bit rnd);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(m, d));
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no accept, want accept within 50 cycles");
                break;
            end
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [W-1:0] g;
        int           base;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        #12 rst = 1'b0;
        idle(1);

        // Basic encode / decode
        out_ready = 1'b1;
        send(2'b00, 4'b1011, 0);
        chk("enc_1011", 32'(out_data), 32'b1110);
        chk("enc_err", 32'(out_err), 0);
        chk("enc_valid", 32'(out_valid), 1);
        send(2'b01, 4'b1110, 0);
        chk("dec_1110", 32'(out_data), 32'b1011);

        // Round trip sweep
        for (int v = 0; v < 16; v++) begin
            send(2'b00, W'(v), 0);
            g = out_data;
            send(2'b01, g, 0);
            chk("roundtrip", 32'(out_data), 32'(v));
        end

        // Step modes and wrap
`ifdef GRAY_CODEC_STEP_EN
        send(2'b10, 4'b1000, 0);
        chk("inc_wrap", 32'(out_data), 32'b0000);
        send(2'b11, 4'b0000, 0);
        chk("dec_wrap", 32'(out_data), 32'b1000);
        send(2'b10, 4'b0001, 0);
        chk("inc_0001", 32'(out_data), 32'b0011);
        chk("inc_err", 32'(out_err), 0);
`else
        send(2'b10, 4'b0001, 0);
        chk("inc_off_data", 32'(out_data), 32'b0000);
        chk("inc_off_err", 32'(out_err), 1);
        send(2'b11, 4'b0000, 0);
        chk("dec_off_err", 32'(out_err), 1);
`endif
        idle(2);

        // Backpressure: hold 0010 for 3 cycles with second word waiting
        out_ready = 1'b0;
        send(2'b00, 4'b0011, 0);
        base = n_out;
        in_valid = 1'b1;
        in_mode  = 2'b00;
        in_data  = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold_data", 32'(out_data), 32'b0010);
            chk("stall_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(2'b00, 4'b0101, 0);
        chk("stall_second", 32'(out_data), 32'b0111);
        idle(2);
        chk("stall_count", 32'(n_out - base), 2);

        // Continuous stream of 8 words
        base = n_out;
        for (int i = 0; i < 8; i++) send(2'b00, W'($urandom_range(0, 15)), 0);
        idle(2);
        chk("stream_count", 32'(n_out - base), 8);
        chk("stream_consec", 32'(out_cycles[$] - out_cycles[$-7]), 7);

        // Async reset mid-cycle while holding a word
        out_ready = 1'b0;
        send(2'b00, 4'b0110, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_mode", 32'(out_mode), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        q.delete();
        base = n_out;
        in_valid = 1'b1;
        in_data  = 4'b1111;
        @(posedge clk);
        #1;
        chk("arst_ignore", 32'(out_valid), 0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("arst_no_deliver", 32'(n_out - base), 0);
        send(2'b00, 4'b0100, 0);
        chk("post_rst_first", 32'(out_data), 32'b0110);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) idle(1);
            send(2'($urandom_range(0, 3)), W'($urandom_range(0, 15)), 1);
        end

        // Drain
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("drain_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
